// File: rtl/iagc_controller_if.sv
// iagc_controller_if: host, IAGC and watchdog signals seen by the IAGC sequencing controller
interface iagc_controller_if #(
   parameter int IAGC_STATUS_SIZE = 4
);
   logic [IAGC_STATUS_SIZE-1:0] i_iagcStatus;
   logic                        i_watchdogValid;
   logic                        i_startRequest;
   logic                        i_clearFault;
   logic                        o_iagcStart;
   logic                        o_iagcReset;
   logic                        o_busy;
   logic                        o_done;
   logic                        o_fault;
   logic [7:0]                  o_retryCount;
   modport master (
      output i_iagcStatus, i_watchdogValid, i_startRequest, i_clearFault,
      input  o_iagcStart, o_iagcReset, o_busy, o_done, o_fault, o_retryCount
   );
   modport slave (
      input  i_iagcStatus, i_watchdogValid, i_startRequest, i_clearFault,
      output o_iagcStart, o_iagcReset, o_busy, o_done, o_fault, o_retryCount
   );
endinterface

// File: rtl/iagc_controller.sv
// iagc_controller: launches IAGC runs, supervises them with timeouts and recovers with bounded retries
module iagc_controller #(
   parameter int                          IAGC_STATUS_SIZE  = 4,
   parameter logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_ERROR = 4'b1000,
   parameter int                          ACK_TIMEOUT       = 1000,
   parameter int                          RUN_TIMEOUT       = 120000000,
   parameter int                          RESET_CYCLES      = 16,
   parameter int                          MAX_RETRIES       = 3
) (
   input logic i_clock,
   input logic i_reset,
   iagc_controller_if.slave bus
);
   typedef enum logic [2:0] {IDLE, START, RUN, RECOVER, FAULT} state_t;
   localparam logic [IAGC_STATUS_SIZE-1:0] STATUS_IDLE = IAGC_STATUS_SIZE'(4'b0010);
   localparam logic [31:0] ACK_LAST = 32'(ACK_TIMEOUT - 1);
   localparam logic [31:0] RUN_LAST = 32'(RUN_TIMEOUT - 1);
   localparam logic [31:0] RST_LAST = 32'(RESET_CYCLES - 1);
   localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);
   state_t      state, state_nx;
   logic [31:0] timer;
   logic [7:0]  retry, retry_nx;
   logic        done_nx, fail, st_idle;
   assign st_idle = bus.i_iagcStatus == STATUS_IDLE;
   assign bus.o_retryCount = retry;
   always_comb begin
      state_nx = state;
      retry_nx = retry;
      done_nx = 1'b0;
      fail = 1'b0;
      case (state)
         IDLE:    state_nx = !bus.i_watchdogValid ? RECOVER : (bus.i_startRequest && st_idle) ? START : IDLE;
         START:   if (!st_idle) state_nx = RUN;
                  else fail = timer == ACK_LAST;
         RUN:     if (st_idle) begin
                     done_nx = 1'b1;
                     retry_nx = '0;
                     state_nx = IDLE;
                  end else fail = bus.i_iagcStatus == IAGC_STATUS_ERROR || timer == RUN_LAST;
         RECOVER: state_nx = timer == RST_LAST ? START : RECOVER;
         FAULT:   if (bus.i_clearFault) begin
                     state_nx = IDLE;
                     retry_nx = '0;
                  end
         default: state_nx = IDLE;
      endcase
      // exhausted retries latch FAULT with the count left at its maximum
      if (fail) begin
         state_nx = retry == RETRY_MAX ? FAULT : RECOVER;
         retry_nx = retry == RETRY_MAX ? retry : retry + 8'd1;
      end
   end
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= IDLE;
         timer <= '0;
         retry <= '0;
         bus.o_iagcStart <= 1'b0;
         bus.o_iagcReset <= 1'b0;
         bus.o_busy <= 1'b0;
         bus.o_done <= 1'b0;
         bus.o_fault <= 1'b0;
      end else begin
         state <= state_nx;
         timer <= state_nx != state ? '0 : timer + 32'd1;
         retry <= retry_nx;
         bus.o_iagcStart <= state_nx == START && state != START;
         bus.o_iagcReset <= state_nx == RECOVER;
         bus.o_busy <= state_nx inside {START, RUN, RECOVER};
         bus.o_done <= done_nx;
         bus.o_fault <= state_nx == FAULT;
      end
   end
endmodule

// File: doc/iagc_controller.md
# iagc_controller

Sequencing and recovery controller for the IAGC. It launches IAGC runs on host request, supervises each run with acknowledge and completion timeouts, and reacts to the watchdog's `o_valid`. On any failure it resets the IAGC and retries a bounded number of times, then latches a fault. It sits between the host command interface, the IAGC core and the watchdog, and consumes the same `i_iagcStatus` bus as the watchdog.

## Interface
Parameters:
- `IAGC_STATUS_SIZE`, 4: width of the IAGC status bus.
- `IAGC_STATUS_ERROR`, 4'b1000: status code meaning the run aborted with an error.
- `ACK_TIMEOUT`, 1000: cycles allowed in START for the IAGC to leave idle. Must be ≥ 2.
- `RUN_TIMEOUT`, 120000000: cycles allowed in RUN for the IAGC to return to idle. Must be ≥ 2 and < 2^32.
- `RESET_CYCLES`, 16: width of the `o_iagcReset` pulse, in cycles. Must be ≥ 1.
- `MAX_RETRIES`, 3: number of recovery attempts before entering FAULT. Must be ≤ 255.

Ports (name, direction, width, meaning):
- `i_clock`, in, 1: single clock; all logic on the rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_iagcStatus`, in, IAGC_STATUS_SIZE: IAGC status. The idle code is fixed at 4'b0010.
- `i_watchdogValid`, in, 1: `o_valid` from the watchdog. 0 means the IAGC is stuck idle without gate activity.
- `i_startRequest`, in, 1: level-sensitive host request to start a run.
- `i_clearFault`, in, 1: host acknowledge that exits FAULT.
- `o_iagcStart`, out, 1: one-cycle start pulse to the IAGC.
- `o_iagcReset`, out, 1: reset to the IAGC core.
- `o_busy`, out, 1: high in START, RUN and RECOVER.
- `o_done`, out, 1: one-cycle pulse when a run completes successfully.
- `o_fault`, out, 1: high while in FAULT.
- `o_retryCount`, out, 8: number of recoveries performed in the current run attempt.

## Operation
- FSM states: IDLE, START, RUN, RECOVER, FAULT. A 32-bit `timer` clears on every state transition.
- **IDLE**
  - If `i_watchdogValid`==0, go to RECOVER. This has priority over a start request.
  - Else if `i_startRequest`==1 and status==IDLE, go to START.
  - A start request while status≠IDLE is held off. It is not lost while the request stays high.
- **START**
  - `o_iagcStart`=1 on the first START cycle only.
  - If status≠IDLE in any START cycle, go to RUN.
  - Else, when `timer`==ACK_TIMEOUT-1, take the failure path.
- **RUN**
  - If status==IDLE: pulse `o_done`, clear `o_retryCount`, go to IDLE.
  - Else if status==IAGC_STATUS_ERROR: failure path.
  - Else, when `timer`==RUN_TIMEOUT-1: failure path.
- **Failure path**
  - If `o_retryCount`==MAX_RETRIES, go to FAULT.
  - Otherwise increment `o_retryCount` and go to RECOVER.
- **RECOVER**
  - `o_iagcReset`=1 for exactly RESET_CYCLES cycles, then go to START. The run is re-launched automatically with no host request needed.
  - Entry from IDLE on watchdog timeout does not increment `o_retryCount`.
- **FAULT**
  - `o_fault`=1. `i_startRequest` and `i_watchdogValid` are ignored.
  - `i_clearFault`=1 returns to IDLE and clears `o_retryCount`.
- Host requests arriving during START, RUN or RECOVER are ignored (no queueing).

## Timing
- All outputs are registered. Reset values: `o_iagcStart`=0, `o_iagcReset`=0, `o_busy`=0, `o_done`=0, `o_fault`=0, `o_retryCount`=0; state IDLE, `timer`=0.
- Start pulse: a request sampled at edge N drives `o_iagcStart`=1 and `o_busy`=1 during cycle N+1.
- Done pulse: `o_done` is high for the single cycle after the edge at which RUN samples status==IDLE. `o_busy` falls in that same cycle.
- START timeout: with no acknowledge, START lasts exactly ACK_TIMEOUT cycles. If status leaves idle on the timeout cycle itself, RUN wins.
- RUN timeout: RUN lasts at most RUN_TIMEOUT cycles. Completion on the timeout cycle counts as success.
- Status sampling in START: status is sampled on every START cycle, including the pulse cycle.
- RECOVER to START: `o_iagcReset` falls in the same cycle START's `o_iagcStart` rises; there is no gap.
- `i_reset` mid-operation: the state machine returns to IDLE on the next edge and all outputs are deasserted in that cycle, including an in-progress `o_iagcReset` pulse.
- Simultaneous `i_clearFault` and `i_startRequest` in FAULT: return to IDLE only. The start is taken on a later cycle if the request is still high.

## Test plan
Parameters for all scenarios: ACK_TIMEOUT=8, RUN_TIMEOUT=32, RESET_CYCLES=4, MAX_RETRIES=2, ERROR=4'b1000.

1. **Normal run.** Request with status 0010. Status goes to 0001 three cycles after the pulse and back to 0010 ten cycles later. Required: one `o_iagcStart` pulse, one `o_done` pulse, `o_busy` high across the run, `o_retryCount` stays 0.
2. **No acknowledge.** Status stuck at 0010. Required:
   - `o_iagcStart`, then 8 START cycles, then `o_iagcReset` for 4 cycles; this repeats 3 times.
   - `o_retryCount` reaches 2, then `o_fault`=1.
   - Exactly 3 start pulses and 2 reset pulses in total.
3. **Error mid-run.** Status 0001, then 1000 in cycle 5 of RUN. Required: `o_retryCount`=1, 4-cycle reset pulse, restart pulse. A clean completion then gives `o_done` and `o_retryCount`=0.
4. **Watchdog recovery.** In IDLE, drive `i_watchdogValid`=0 together with `i_startRequest`=1. Required: RECOVER is taken first (reset pulse of 4 cycles), then an automatic start, with `o_retryCount`=0.
5. **Reset during RECOVER.** Assert `i_reset` on the 2nd reset cycle. Required: all outputs 0 on the next cycle and state IDLE. A subsequent request produces a normal run.
6. **Fault clear.** Hold `i_startRequest`=1 while in FAULT: no pulse is issued. Pulse `i_clearFault` with the request still high. Required: IDLE for one cycle, then `o_iagcStart`, with `o_retryCount` reset to 0.
